// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only bus between the boot checker (master) and the sysid
// control port (slave).
interface sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
    modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and reports whether they
// match the build-time values; retries stalled reads and flags a timeout.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h50AE_E4AF,
    parameter int unsigned CHECK_TS       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    sysid_boot_checker_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        id_ok,
    output logic                        ts_ok,
    output logic                        timeout_err,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, DONE} state_t;

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LP_MAX_RTY  = 4'(MAX_RETRIES);
    localparam bit          LP_CHK_TS   = (CHECK_TS != 0);

    state_t      r_state;
    logic        r_auto;
    logic        r_read;
    logic        r_addr;
    logic        r_gap;
    logic [15:0] r_wait;
    logic [3:0]  r_retry;
    logic        w_ts_match;

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_addr;
    assign w_ts_match      = !LP_CHK_TS || (ts_value == EXPECTED_TS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_auto      <= (AUTO_START != 0);
            r_read      <= 1'b0;
            r_addr      <= 1'b0;
            r_gap       <= 1'b0;
            r_wait      <= '0;
            r_retry     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start || r_auto) begin
                        r_auto      <= 1'b0;
                        r_state     <= RD_ID;
                        r_read      <= 1'b1;
                        r_addr      <= 1'b0;
                        r_gap       <= 1'b0;
                        r_wait      <= '0;
                        r_retry     <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (r_gap) begin
                        // One idle cycle after an abandoned transfer, then re-issue.
                        r_gap  <= 1'b0;
                        r_read <= 1'b1;
                    end else if (!avm.avm_waitrequest) begin
                        r_wait  <= '0;
                        r_retry <= '0;
                        if (r_state == RD_ID) begin
                            id_value <= avm.avm_readdata;
                            if (LP_CHK_TS) begin
                                r_state <= RD_TS;
                                r_addr  <= 1'b1;
                            end else begin
                                r_state <= CMP;
                                r_read  <= 1'b0;
                            end
                        end else begin
                            ts_value <= avm.avm_readdata;
                            r_state  <= CMP;
                            r_read   <= 1'b0;
                            r_addr   <= 1'b0;
                        end
                    end else if (r_wait == LP_TMO_LAST) begin
                        r_wait <= '0;
                        r_read <= 1'b0;
                        if (r_retry >= LP_MAX_RTY) begin
                            // Out of retries: only a word already captured can be judged.
                            r_state     <= DONE;
                            r_addr      <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            timeout_err <= 1'b1;
                            id_ok       <= (r_state == RD_TS) && (id_value == EXPECTED_ID);
                        end else begin
                            r_retry <= r_retry + 4'd1;
                            r_gap   <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                CMP: begin
                    id_ok   <= (id_value == EXPECTED_ID);
                    ts_ok   <= w_ts_match;
                    pass    <= (id_value == EXPECTED_ID) && w_ts_match;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed and randomized checks of sysid_boot_checker against three slave
// models: variable-wait, stuck-waitrequest, and zero-wait ID-only.
module tb_sysid_boot_checker;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h50AE_E4AF;
    localparam int B_TMO = 4;
    localparam int B_MR  = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
    int   total = 0, bad = 0;

    sysid_boot_checker_if ifa();
    sysid_boot_checker_if ifb();
    sysid_boot_checker_if ifc();

    logic a_busy, a_done, a_pass, a_idok, a_tsok, a_te;
    logic b_busy, b_done, b_pass, b_idok, b_tsok, b_te;
    logic c_busy, c_done, c_pass, c_idok, c_tsok, c_te;
    logic [31:0] a_id, a_ts, b_id, b_ts, c_id, c_ts;

    sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1),
        .TIMEOUT_CYCLES(255), .MAX_RETRIES(2), .AUTO_START(1)) u_a (
        .clock(clock), .reset_n(rst_a), .start(st_a), .avm(ifa.master),
        .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_idok), .ts_ok(a_tsok),
        .timeout_err(a_te), .id_value(a_id), .ts_value(a_ts));

    sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1),
        .TIMEOUT_CYCLES(B_TMO), .MAX_RETRIES(B_MR), .AUTO_START(1)) u_b (
        .clock(clock), .reset_n(rst_b), .start(st_b), .avm(ifb.master),
        .busy(b_busy), .done(b_done), .pass(b_pass), .id_ok(b_idok), .ts_ok(b_tsok),
        .timeout_err(b_te), .id_value(b_id), .ts_value(b_ts));

    sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(0),
        .TIMEOUT_CYCLES(255), .MAX_RETRIES(2), .AUTO_START(0)) u_c (
        .clock(clock), .reset_n(rst_c), .start(st_c), .avm(ifc.master),
        .busy(c_busy), .done(c_done), .pass(c_pass), .id_ok(c_idok), .ts_ok(c_tsok),
        .timeout_err(c_te), .id_value(c_id), .ts_value(c_ts));

    // Slave A: stalls each read for a programmable number of cycles per address.
    int          a_wait [2] = '{0, 0};
    logic [31:0] a_data [2] = '{EXP_ID, EXP_TS};
    int          a_wc = 0;
    assign ifa.avm_waitrequest = ifa.avm_read && (a_wc < a_wait[ifa.avm_address]);
    assign ifa.avm_readdata    = a_data[ifa.avm_address];
    always @(posedge clock)
        if (!ifa.avm_read || !ifa.avm_waitrequest) a_wc <= 0;
        else a_wc <= a_wc + 1;

    assign ifb.avm_waitrequest = 1'b1;
    assign ifb.avm_readdata    = 32'h0;

    int c_rd0 = 0, c_rd1 = 0;
    assign ifc.avm_waitrequest = 1'b0;
    assign ifc.avm_readdata    = ifc.avm_address ? 32'hDEAD_BEEF : EXP_ID;
    always @(posedge clock)
        if (ifc.avm_read) begin
            if (ifc.avm_address) c_rd1 <= c_rd1 + 1;
            else c_rd0 <= c_rd0 + 1;
        end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    // Start a check on A, wait for done and compare against the reference rules.
    task automatic run_a(input logic [31:0] id, input logic [31:0] ts, input int wi, input int wt);
        int n;
        int exp_lat;
        a_data[0] = id; a_data[1] = ts; a_wait[0] = wi; a_wait[1] = wt;
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        chk1("rnd_busy_rise", a_busy, 1'b1);
        chk1("rnd_done_clr", a_done, 1'b0);
        n = 1;
        while (!a_done && n < 60) begin
            tick();
            n++;
        end
        exp_lat = 1 + (wi + 1) + (wt + 1) + 1;
        chk("rnd_latency", 32'(n), 32'(exp_lat));
        chk1("rnd_id_ok", a_idok, id == EXP_ID);
        chk1("rnd_ts_ok", a_tsok, ts == EXP_TS);
        chk1("rnd_pass", a_pass, (id == EXP_ID) && (ts == EXP_TS));
        chk("rnd_id_value", a_id, id);
        chk("rnd_ts_value", a_ts, ts);
        chk1("rnd_tmo", a_te, 1'b0);
        chk1("rnd_busy_fall", a_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_rd [$];
        repeat (3) tick();
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_done", a_done, 1'b0);
        chk1("rst_pass", a_pass, 1'b0);
        chk1("rst_read", ifa.avm_read, 1'b0);
        chk("rst_id_value", a_id, 32'h0);

        // Auto launch after reset, zero-wait slave.
        rst_a = 1'b1;
        tick();
        chk1("auto_rd1", ifa.avm_read, 1'b1);
        chk1("auto_addr1", ifa.avm_address, 1'b0);
        tick();
        chk1("auto_rd2", ifa.avm_read, 1'b1);
        chk1("auto_addr2", ifa.avm_address, 1'b1);
        tick();
        chk1("auto_rd3", ifa.avm_read, 1'b0);
        chk1("auto_done3", a_done, 1'b0);
        tick();
        chk1("auto_done4", a_done, 1'b1);
        chk1("auto_pass", a_pass, 1'b1);
        chk("auto_id", a_id, EXP_ID);
        chk("auto_ts", a_ts, EXP_TS);
        repeat (3) tick();
        chk1("auto_once", a_busy, 1'b0);

        // Wrong ID word.
        run_a(32'h0000_0001, EXP_TS, 0, 0);

        // Timestamp read stalled three cycles.
        a_data[0] = EXP_ID; a_data[1] = EXP_TS; a_wait[0] = 0; a_wait[1] = 3;
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        chk1("wait_addr0", ifa.avm_address, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk1("wait_hold_rd", ifa.avm_read, 1'b1);
            chk1("wait_hold_addr", ifa.avm_address, 1'b1);
        end
        tick();
        chk1("wait_done6", a_done, 1'b0);
        tick();
        chk1("wait_done7", a_done, 1'b1);
        chk1("wait_pass", a_pass, 1'b1);
        chk1("wait_tmo", a_te, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] id, ts;
            id = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            ts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            run_a(id, ts, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end

        // Reset while the timestamp read is stalled, then auto re-run.
        a_data[0] = EXP_ID; a_data[1] = EXP_TS; a_wait[0] = 0; a_wait[1] = 20;
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        tick();
        tick();
        chk1("mid_in_ts", ifa.avm_address, 1'b1);
        rst_a = 1'b0;
        #1;
        chk1("mid_rd_drop", ifa.avm_read, 1'b0);
        chk1("mid_busy", a_busy, 1'b0);
        chk1("mid_done", a_done, 1'b0);
        chk("mid_id", a_id, 32'h0);
        tick();
        rst_a = 1'b1;
        a_wait[1] = 0;
        tick();
        chk1("mid_rerun_rd", ifa.avm_read, 1'b1);
        chk1("mid_rerun_addr", ifa.avm_address, 1'b0);
        repeat (3) tick();
        chk1("mid_rerun_done", a_done, 1'b1);
        chk1("mid_rerun_pass", a_pass, 1'b1);

        // Stuck slave: each attempt waits the full timeout, gap between attempts.
        for (int a = 0; a <= B_MR; a++) begin
            repeat (B_TMO) exp_rd.push_back(1'b1);
            if (a < B_MR) exp_rd.push_back(1'b0);
        end
        rst_b = 1'b1;
        foreach (exp_rd[k]) begin
            tick();
            chk1("tmo_rd_pattern", ifb.avm_read, exp_rd[k]);
        end
        tick();
        chk1("tmo_done", b_done, 1'b1);
        chk1("tmo_err", b_te, 1'b1);
        chk1("tmo_pass", b_pass, 1'b0);
        chk1("tmo_busy", b_busy, 1'b0);
        chk1("tmo_rd_off", ifb.avm_read, 1'b0);

        // ID-only, manual start, second start while busy.
        rst_c = 1'b1;
        repeat (3) tick();
        chk1("c_no_auto", c_busy, 1'b0);
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        chk1("c_busy", c_busy, 1'b1);
        chk1("c_rd_addr", ifc.avm_address, 1'b0);
        tick();
        st_c = 1'b1;
        chk1("c_done2", c_done, 1'b0);
        tick();
        st_c = 1'b0;
        chk1("c_done3", c_done, 1'b1);
        chk1("c_ts_ok", c_tsok, 1'b1);
        chk("c_ts_value", c_ts, 32'h0);
        chk1("c_pass", c_pass, 1'b1);
        repeat (4) tick();
        chk("c_id_reads", 32'(c_rd0), 32'd1);
        chk("c_ts_reads", 32'(c_rd1), 32'd0);
        chk1("c_held_done", c_done, 1'b1);
        chk1("c_idle_busy", c_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
